// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register for the EX/MEM control and result fields
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
    parameter int WB_W   = 1,
    parameter int M_W    = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB_in,
    input  logic [M_W-1:0]    M_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [REG_W-1:0]  write_register_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WB_out,
    output logic [M_W-1:0]    M_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic [REG_W-1:0]  write_register_out
);

    logic [WB_W-1:0] wb_cap;
    logic            capture;
    logic            rel;

    // A write to register 0 must never reach the register file.
    assign wb_cap  = (write_register_in == '0) ? '0 : WB_in;
    assign capture = in_valid && in_ready;
    assign rel     = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [WB_W-1:0]   skid_wb;
    logic [M_W-1:0]    skid_m;
    logic [DATA_W-1:0] skid_alu;
    logic [REG_W-1:0]  skid_reg;

    // skid_valid is a flop, so in_ready has no path from out_ready.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid          <= 1'b0;
            WB_out             <= '0;
            M_out              <= '0;
            ALUresult_out      <= '0;
            write_register_out <= '0;
            skid_valid         <= 1'b0;
            skid_wb            <= '0;
            skid_m             <= '0;
            skid_alu           <= '0;
            skid_reg           <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            WB_out     <= '0;
            M_out      <= '0;
            skid_valid <= 1'b0;
        end else if (rel && skid_valid) begin
            out_valid          <= 1'b1;
            WB_out             <= skid_wb;
            M_out              <= skid_m;
            ALUresult_out      <= skid_alu;
            write_register_out <= skid_reg;
            skid_valid         <= 1'b0;
        end else if (capture && (rel || !out_valid)) begin
            out_valid          <= 1'b1;
            WB_out             <= wb_cap;
            M_out              <= M_in;
            ALUresult_out      <= ALUresult_in;
            write_register_out <= write_register_in;
        end else if (capture) begin
            skid_valid <= 1'b1;
            skid_wb    <= wb_cap;
            skid_m     <= M_in;
            skid_alu   <= ALUresult_in;
            skid_reg   <= write_register_in;
        end else if (rel) begin
            out_valid <= 1'b0;
            WB_out    <= '0;
            M_out     <= '0;
        end
    end
`else
    assign in_ready = out_ready || !out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid          <= 1'b0;
            WB_out             <= '0;
            M_out              <= '0;
            ALUresult_out      <= '0;
            write_register_out <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            WB_out    <= '0;
            M_out     <= '0;
        end else if (capture) begin
            out_valid          <= 1'b1;
            WB_out             <= wb_cap;
            M_out              <= M_in;
            ALUresult_out      <= ALUresult_in;
            write_register_out <= write_register_in;
        end else if (rel) begin
            // Bubble: control fields go to zero, data fields keep their last value.
            out_valid <= 1'b0;
            WB_out    <= '0;
            M_out     <= '0;
        end
    end
`endif

endmodule
